branch_prediction_controller: RTL and testbench

- Sequences the fetch-stage branch predictor and branch target buffer (BTB).
- After reset, walks and invalidates every BTB entry.
- Gates fetch-side predictions, resolves predictions in Execute, and drives redirect, flush and predictor/BTB update enables.
- Sits between the fetch predictors and the Execute-stage branch unit, and keeps saturating performance counters.

---
 rtl/branch_prediction_controller.sv | 125 ++++++++++++
 tb/tb_branch_prediction_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_prediction_controller.sv
// Fetch/Execute branch-prediction sequencer: post-reset BTB invalidate walk,
// fetch prediction gating, Execute-stage resolution, flush timing and perf counters.
module branch_prediction_controller #(
    parameter int BTB_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           Valid_F,
    input  logic                           Predict_Out,
    output logic                           Predict_Taken_F,
    output logic                           Stall_F,
    output logic                           Clear_En,
    output logic [$clog2(BTB_ENTRIES)-1:0] Clear_Index,
    input  logic                           Branch_E,
    input  logic                           Predict_Taken_E,
    input  logic                           Branch_Taken_E,
    input  logic [31:0]                    PC_Target_E,
    input  logic [31:0]                    PC_Plus4_E,
    input  logic [31:0]                    Pred_Target_E,
    output logic                           Redirect,
    output logic [31:0]                    Redirect_PC,
    output logic                           Flush_D,
    output logic                           Flush_E,
    output logic                           Update_BP,
    output logic                           Update_BTB,
    output logic [CNT_WIDTH-1:0]           Branch_Count,
    output logic [CNT_WIDTH-1:0]           Mispredict_Count
);

    localparam int IDX_W      = $clog2(BTB_ENTRIES);
    localparam int FC_W       = $clog2(FLUSH_CYCLES + 1);
    // The mispredict cycle itself is the first flush cycle, so FLUSH holds the remainder.
    localparam int FLUSH_LOAD = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_clr_idx;
    logic [FC_W-1:0]       r_flush_cnt;
    logic [31:0]           r_redirect_pc;
    logic [CNT_WIDTH-1:0]  r_br_cnt;
    logic [CNT_WIDTH-1:0]  r_mis_cnt;

    logic                  w_run;
    logic                  w_branch;
    logic                  w_dir_miss;
    logic                  w_tgt_miss;
    logic                  w_mispredict;
    logic [31:0]           w_fix_pc;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign w_run        = (r_state == S_RUN);
    assign w_branch     = w_run & Branch_E;
    assign w_dir_miss   = (Predict_Taken_E != Branch_Taken_E);
    assign w_tgt_miss   = Predict_Taken_E & Branch_Taken_E & (Pred_Target_E != PC_Target_E);
    assign w_mispredict = w_branch & (w_dir_miss | w_tgt_miss);
    assign w_fix_pc     = Branch_Taken_E ? PC_Target_E : PC_Plus4_E;

    assign Predict_Taken_F  = Valid_F & Predict_Out & w_run;
    assign Stall_F          = (r_state == S_CLEAR);
    assign Clear_En         = (r_state == S_CLEAR);
    assign Clear_Index      = r_clr_idx;
    assign Update_BP        = w_branch;
    assign Update_BTB       = w_branch & Branch_Taken_E;
    assign Redirect         = w_mispredict;
    assign Redirect_PC      = w_mispredict ? w_fix_pc : r_redirect_pc;
    assign Flush_D          = w_mispredict | (r_state == S_FLUSH);
    assign Flush_E          = w_mispredict | (r_state == S_FLUSH);
    assign Branch_Count     = r_br_cnt;
    assign Mispredict_Count = r_mis_cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state       <= S_CLEAR;
            r_clr_idx     <= '0;
            r_flush_cnt   <= '0;
            r_redirect_pc <= '0;
            r_br_cnt      <= '0;
            r_mis_cnt     <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clr_idx <= r_clr_idx + IDX_W'(1);
                    if (r_clr_idx == IDX_W'(BTB_ENTRIES - 1)) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_mispredict) begin
                        r_redirect_pc <= w_fix_pc;
                        if (FLUSH_CYCLES > 1) begin
                            r_state     <= S_FLUSH;
                            r_flush_cnt <= FC_W'(FLUSH_LOAD);
                        end
                    end
                end
                S_FLUSH: begin
                    if (r_flush_cnt == '0) begin
                        r_state <= S_RUN;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - FC_W'(1);
                    end
                end
                default: r_state <= S_CLEAR;
            endcase
            // w_branch and w_mispredict are already gated to RUN, so squashed branches never count.
            if (w_branch) begin
                r_br_cnt <= sat_inc(r_br_cnt);
            end
            if (w_mispredict) begin
                r_mis_cnt <= sat_inc(r_mis_cnt);
            end
        end
    end

endmodule

// File: tb/tb_branch_prediction_controller.sv
// Bench for branch_prediction_controller: directed literal checks plus randomized
// traffic compared every cycle against a behavioural model (16-bit and 4-bit counter instances).
module tb_branch_prediction_controller;

    localparam int BTB  = 16;
    localparam int FC   = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        Valid_F, Predict_Out;
    logic        Branch_E, Predict_Taken_E, Branch_Taken_E;
    logic [31:0] PC_Target_E, PC_Plus4_E, Pred_Target_E;

    logic        a_ptf, a_stall, a_clr, a_red, a_fd, a_fe, a_ubp, a_ubtb;
    logic [3:0]  a_idx;
    logic [31:0] a_rpc;
    logic [15:0] a_bc, a_mc;

    logic        b_ptf, b_stall, b_clr, b_red, b_fd, b_fe, b_ubp, b_ubtb;
    logic [3:0]  b_idx;
    logic [31:0] b_rpc;
    logic [3:0]  b_bc, b_mc;

    int n_vec  = 0;
    int n_fail = 0;

    // Model state, expressed as elapsed clear cycles / remaining flush cycles / plain counts.
    int          m_cyc  = 0;
    int          m_frem = 0;
    int          m_br   = 0;
    int          m_mis  = 0;
    logic [31:0] m_rpc  = 32'h0;

    always #5 CLK = ~CLK;

    branch_prediction_controller #(.BTB_ENTRIES(BTB), .FLUSH_CYCLES(FC), .CNT_WIDTH(16)) dut (
        .CLK(CLK), .RST(RST), .Valid_F(Valid_F), .Predict_Out(Predict_Out),
        .Predict_Taken_F(a_ptf), .Stall_F(a_stall), .Clear_En(a_clr), .Clear_Index(a_idx),
        .Branch_E(Branch_E), .Predict_Taken_E(Predict_Taken_E), .Branch_Taken_E(Branch_Taken_E),
        .PC_Target_E(PC_Target_E), .PC_Plus4_E(PC_Plus4_E), .Pred_Target_E(Pred_Target_E),
        .Redirect(a_red), .Redirect_PC(a_rpc), .Flush_D(a_fd), .Flush_E(a_fe),
        .Update_BP(a_ubp), .Update_BTB(a_ubtb), .Branch_Count(a_bc), .Mispredict_Count(a_mc)
    );

    branch_prediction_controller #(.BTB_ENTRIES(BTB), .FLUSH_CYCLES(FC), .CNT_WIDTH(4)) dut4 (
        .CLK(CLK), .RST(RST), .Valid_F(Valid_F), .Predict_Out(Predict_Out),
        .Predict_Taken_F(b_ptf), .Stall_F(b_stall), .Clear_En(b_clr), .Clear_Index(b_idx),
        .Branch_E(Branch_E), .Predict_Taken_E(Predict_Taken_E), .Branch_Taken_E(Branch_Taken_E),
        .PC_Target_E(PC_Target_E), .PC_Plus4_E(PC_Plus4_E), .Pred_Target_E(Pred_Target_E),
        .Redirect(b_red), .Redirect_PC(b_rpc), .Flush_D(b_fd), .Flush_E(b_fe),
        .Update_BP(b_ubp), .Update_BTB(b_ubtb), .Branch_Count(b_bc), .Mispredict_Count(b_mc)
    );

    // Every-cycle compare against the model; model advances after the expectation is formed.
    always @(negedge CLK) begin
        logic        e_ptf, e_stall, e_clr, e_red, e_fd, e_ubp, e_ubtb, e_mis;
        logic [3:0]  e_idx;
        logic [31:0] e_rpc;
        int          e_br, e_mc;
        logic [75:0] got_a, exp_a;
        logic [51:0] got_b, exp_b;
        e_ptf = 0; e_stall = 0; e_clr = 0; e_red = 0; e_fd = 0; e_ubp = 0; e_ubtb = 0;
        e_idx = 4'h0; e_mis = 0;
        if (!RST) begin
            m_cyc = 0; m_frem = 0; m_br = 0; m_mis = 0; m_rpc = 32'h0;
            e_stall = 1; e_clr = 1;
            e_rpc = 32'h0; e_br = 0; e_mc = 0;
        end else begin
            e_rpc = m_rpc; e_br = m_br; e_mc = m_mis;
            if (m_cyc < BTB) begin
                e_stall = 1; e_clr = 1; e_idx = 4'(m_cyc);
                m_cyc++;
            end else if (m_frem > 0) begin
                e_fd = 1;
                m_frem--;
            end else begin
                e_ptf  = Valid_F & Predict_Out;
                e_ubp  = Branch_E;
                e_ubtb = Branch_E & Branch_Taken_E;
                if (Branch_E) begin
                    e_mis = (Predict_Taken_E ^ Branch_Taken_E) ||
                            (Predict_Taken_E && Branch_Taken_E && Pred_Target_E != PC_Target_E);
                    m_br++;
                end
                if (e_mis) begin
                    e_red  = 1; e_fd = 1;
                    m_rpc  = Branch_Taken_E ? PC_Target_E : PC_Plus4_E;
                    e_rpc  = m_rpc;
                    m_frem = FC - 1;
                    m_mis++;
                end
            end
        end
        got_a = {a_ptf, a_stall, a_clr, a_idx, a_red, a_rpc, a_fd, a_fe, a_ubp, a_ubtb, a_bc, a_mc};
        exp_a = {e_ptf, e_stall, e_clr, e_idx, e_red, e_rpc, e_fd, e_fd, e_ubp, e_ubtb,
                 16'((e_br > 65535) ? 65535 : e_br), 16'((e_mc > 65535) ? 65535 : e_mc)};
        got_b = {b_ptf, b_stall, b_clr, b_idx, b_red, b_rpc, b_fd, b_fe, b_ubp, b_ubtb, b_bc, b_mc};
        exp_b = {e_ptf, e_stall, e_clr, e_idx, e_red, e_rpc, e_fd, e_fd, e_ubp, e_ubtb,
                 4'((e_br > 15) ? 15 : e_br), 4'((e_mc > 15) ? 15 : e_mc)};
        n_vec += 2;
        if (got_a !== exp_a) begin
            n_fail++;
            $display("FAIL model16 t=%0t got=%h expected=%h", $time, got_a, exp_a);
        end
        if (got_b !== exp_b) begin
            n_fail++;
            $display("FAIL model4 t=%0t got=%h expected=%h", $time, got_b, exp_b);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic look();
        @(negedge CLK);
        #1;
    endtask

    task automatic br(input logic b, input logic p, input logic t,
                      input logic [31:0] pt, input logic [31:0] tg, input logic [31:0] p4);
        Branch_E = b; Predict_Taken_E = p; Branch_Taken_E = t;
        Pred_Target_E = pt; PC_Target_E = tg; PC_Plus4_E = p4;
    endtask

    initial begin
        Valid_F = 1; Predict_Out = 1;
        br(0, 0, 0, 32'h0, 32'h0, 32'h0);

        look();
        chk("rst_clear_en", 32'(a_clr), 32'h1);
        chk("rst_stall", 32'(a_stall), 32'h1);
        chk("rst_index", 32'(a_idx), 32'h0);
        chk("rst_ptf", 32'(a_ptf), 32'h0);
        step(); RST = 1;
        look();
        chk("clear_idx0", 32'(a_idx), 32'h0);
        for (int k = 1; k < BTB; k++) begin
            step(); look();
            chk("clear_idx", 32'(a_idx), 32'(k));
            chk("clear_ptf", 32'(a_ptf), 32'h0);
        end
        step(); look();
        chk("run_clear_en", 32'(a_clr), 32'h0);
        chk("run_ptf", 32'(a_ptf), 32'h1);

        step(); br(1, 1, 1, 32'h40, 32'h40, 32'h44);
        look();
        chk("hit_upd_bp", 32'(a_ubp), 32'h1);
        chk("hit_upd_btb", 32'(a_ubtb), 32'h1);
        chk("hit_redirect", 32'(a_red), 32'h0);
        step(); br(0, 0, 0, 32'h0, 32'h0, 32'h0);
        look();
        chk("hit_brcnt", 32'(a_bc), 32'h1);
        chk("hit_miscnt", 32'(a_mc), 32'h0);

        step(); br(1, 1, 0, 32'h50, 32'h50, 32'h24);
        look();
        chk("nt_redirect", 32'(a_red), 32'h1);
        chk("nt_rpc", a_rpc, 32'h24);
        chk("nt_upd_btb", 32'(a_ubtb), 32'h0);
        chk("nt_flush", {30'h0, a_fd, a_fe}, 32'h3);
        step(); br(1, 0, 1, 32'h60, 32'h70, 32'h74);
        look();
        chk("fl_flush", {30'h0, a_fd, a_fe}, 32'h3);
        chk("fl_redirect", 32'(a_red), 32'h0);
        chk("fl_upd_bp", 32'(a_ubp), 32'h0);
        chk("fl_miscnt", 32'(a_mc), 32'h1);
        step(); br(0, 0, 0, 32'h0, 32'h0, 32'h0);
        look();
        chk("post_flush", {30'h0, a_fd, a_fe}, 32'h0);
        chk("post_brcnt", 32'(a_bc), 32'h2);
        chk("post_rpc_hold", a_rpc, 32'h24);

        step(); br(1, 1, 1, 32'h80, 32'h90, 32'h94);
        look();
        chk("tgt_redirect", 32'(a_red), 32'h1);
        chk("tgt_rpc", a_rpc, 32'h90);
        chk("tgt_upd_btb", 32'(a_ubtb), 32'h1);
        step(); br(0, 0, 0, 32'h0, 32'h0, 32'h0); RST = 0;
        look();
        chk("rstfl_clear_en", 32'(a_clr), 32'h1);
        chk("rstfl_flush", {30'h0, a_fd, a_fe}, 32'h0);
        chk("rstfl_cnt", {a_bc, a_mc}, 32'h0);
        chk("rstfl_rpc", a_rpc, 32'h0);
        step(); RST = 1;
        look();
        for (int k = 1; k <= 7; k++) begin
            step(); look();
        end
        chk("mid_idx7", 32'(a_idx), 32'h7);
        step(); RST = 0;
        look();
        chk("rstcl_idx", 32'(a_idx), 32'h0);
        chk("rstcl_clear_en", 32'(a_clr), 32'h1);
        step(); RST = 1;
        for (int k = 0; k < BTB; k++) begin
            step();
        end
        look();
        chk("rerun_clear_en", 32'(a_clr), 32'h0);

        for (int k = 0; k < 20; k++) begin
            step(); br(1, 1, 0, 32'h100, 32'h100, $urandom);
            step(); br(0, 0, 0, 32'h0, 32'h0, 32'h0);
            step(); step();
        end
        look();
        chk("sat4_brcnt", 32'(b_bc), 32'hF);
        chk("sat4_miscnt", 32'(b_mc), 32'hF);
        chk("cnt16_brcnt", 32'(a_bc), 32'd20);
        chk("cnt16_miscnt", 32'(a_mc), 32'd20);

        for (int k = 0; k < 3000; k++) begin
            logic [31:0] tg;
            step();
            RST         = ($urandom_range(0, 249) != 0);
            Valid_F     = 1'($urandom);
            Predict_Out = 1'($urandom);
            tg          = ($urandom_range(0, 3) == 0) ? $urandom : 32'h40;
            br(1'($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0) ? 32'h80 : 32'h40, tg, $urandom);
        end
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
